kernel_ctrl: RTL and testbench

KERNEL_CTRL -- requirements
Module: kernel_ctrl

---
 rtl/hog_pkg.sv | 21 ++
 rtl/kernel_ctrl_if.sv | 39 +++
 rtl/kernel_ctrl_pos_counter.sv | 51 +++++
 rtl/kernel_ctrl.sv | 121 ++++++++++++
 tb/tb_kernel_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/hog_pkg.sv
// Shared definitions for the kernel controller: FSM state encoding,
// default image/kernel dimensions and a counter-width helper.
package hog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEF_IMG_WIDTH    = 854;
  localparam int DEF_IMG_HEIGHT   = 480;
  localparam int DEF_BLOCK_WIDTH  = 3;
  localparam int DEF_BLOCK_HEIGHT = 3;

  // Width of a counter indexing 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kernel_ctrl_if.sv
// Kernel stream bundle: line-buffer side (lb_k_*) and downstream side (k_*).
// Optional macro KERNEL_CTRL_BORDER_PASS_EN adds the k_border marker.
interface kernel_ctrl_if
  import hog_pkg::*;
#(
  parameter int COL_W = cnt_width(DEF_IMG_WIDTH),
  parameter int ROW_W = cnt_width(DEF_IMG_HEIGHT)
);
  logic             lb_k_valid;
  logic             lb_k_ready;
  logic             k_valid;
  logic             k_ready;
  logic             k_sof;
  logic             k_eol;
  logic             k_eof;
  logic [COL_W-1:0] k_col;
  logic [ROW_W-1:0] k_row;
`ifdef KERNEL_CTRL_BORDER_PASS_EN
  logic             k_border;

  modport slave (
    input  lb_k_valid, k_ready,
    output lb_k_ready, k_valid, k_sof, k_eol, k_eof, k_col, k_row, k_border
  );
  modport master (
    output lb_k_valid, k_ready,
    input  lb_k_ready, k_valid, k_sof, k_eol, k_eof, k_col, k_row, k_border
  );
`else
  modport slave (
    input  lb_k_valid, k_ready,
    output lb_k_ready, k_valid, k_sof, k_eol, k_eof, k_col, k_row
  );
  modport master (
    output lb_k_valid, k_ready,
    input  lb_k_ready, k_valid, k_sof, k_eol, k_eof, k_col, k_row
  );
`endif
endinterface

// File: rtl/kernel_ctrl_pos_counter.sv
// Wrapping column/row position counter for the kernel stream.
// pos_c counts 0..IMG_WIDTH-1, pos_r counts 0..IMG_HEIGHT-BLOCK_HEIGHT.
module pos_counter
  import hog_pkg::*;
#(
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
  parameter int COL_W        = cnt_width(IMG_WIDTH),
  parameter int ROW_W        = cnt_width(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] pos_c,
  output logic [ROW_W-1:0] pos_r,
  output logic             col_last,
  output logic             row_last
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - BLOCK_HEIGHT);

  logic [COL_W-1:0] pos_c_reg;
  logic [ROW_W-1:0] pos_r_reg;

  assign pos_c    = pos_c_reg;
  assign pos_r    = pos_r_reg;
  assign col_last = (pos_c_reg == COL_MAX);
  assign row_last = (pos_r_reg == ROW_MAX);

  // Advance on each accepted kernel; the row wraps too so nothing overflows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_c_reg <= '0;
      pos_r_reg <= '0;
    end else if (clear) begin
      pos_c_reg <= '0;
      pos_r_reg <= '0;
    end else if (advance) begin
      if (col_last) begin
        pos_c_reg <= '0;
        pos_r_reg <= row_last ? '0 : pos_r_reg + 1'b1;
      end else begin
        pos_c_reg <= pos_c_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kernel_ctrl.sv
// Kernel controller: filters the line-buffer kernel stream down to kernels
// that lie fully inside an image row and tags them with coordinates and
// frame/row markers. Define KERNEL_CTRL_BORDER_PASS_EN to forward the
// row-straddling border kernels as well, flagged by k_border.
module kernel_ctrl
  import hog_pkg::*;
#(
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
  parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  kernel_ctrl_if.slave  kbus
);

  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  // Smallest rightmost-pixel column for which the whole kernel is in-row.
  localparam logic [COL_W-1:0] KEEP_MIN = COL_W'(BLOCK_WIDTH - 1);

  state_t           state_reg, state_next;
  logic [COL_W-1:0] pos_c;
  logic [ROW_W-1:0] pos_r;
  logic             col_last, row_last;
  logic             cnt_clear, cnt_advance;
  logic             keep;
  logic             handshake;

  pos_counter #(
    .IMG_WIDTH    (IMG_WIDTH),
    .IMG_HEIGHT   (IMG_HEIGHT),
    .BLOCK_HEIGHT (BLOCK_HEIGHT),
    .COL_W        (COL_W),
    .ROW_W        (ROW_W)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .pos_c    (pos_c),
    .pos_r    (pos_r),
    .col_last (col_last),
    .row_last (row_last)
  );

  assign keep = (pos_c >= KEEP_MIN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next state, handshake steering and output markers.
  always_comb begin
    state_next      = state_reg;
    busy            = 1'b0;
    frame_done      = 1'b0;
    cnt_clear       = 1'b0;
    cnt_advance     = 1'b0;
    handshake       = 1'b0;
    kbus.lb_k_ready = 1'b0;
    kbus.k_valid    = 1'b0;
    kbus.k_sof      = 1'b0;
    kbus.k_eol      = 1'b0;
    kbus.k_eof      = 1'b0;
    kbus.k_col      = '0;
    kbus.k_row      = '0;
`ifdef KERNEL_CTRL_BORDER_PASS_EN
    kbus.k_border   = 1'b0;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_STREAM;
          cnt_clear  = 1'b1;
        end
      end
      ST_STREAM: begin
        busy       = 1'b1;
        kbus.k_row = pos_r;
        kbus.k_eol = col_last;
        kbus.k_eof = col_last && row_last;
        if (keep) begin
          kbus.k_valid    = kbus.lb_k_valid;
          kbus.lb_k_ready = kbus.k_ready;
          kbus.k_col      = pos_c - KEEP_MIN;
        end else begin
`ifdef KERNEL_CTRL_BORDER_PASS_EN
          // Border kernels travel downstream like any other, column pinned to 0.
          kbus.k_valid    = kbus.lb_k_valid;
          kbus.lb_k_ready = kbus.k_ready;
          kbus.k_border   = 1'b1;
`else
          // Border kernels are drained without reaching downstream.
          kbus.lb_k_ready = 1'b1;
`endif
        end
`ifdef KERNEL_CTRL_BORDER_PASS_EN
        kbus.k_sof = (pos_c == '0) && (pos_r == '0);
`else
        kbus.k_sof = keep && (pos_c == KEEP_MIN) && (pos_r == '0);
`endif
        handshake   = kbus.lb_k_valid && kbus.lb_k_ready;
        cnt_advance = handshake;
        if (handshake && col_last && row_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_kernel_ctrl.sv
// Randomized self-checking bench for kernel_ctrl on an 8x6 image, 3x3 kernel.
module tb_kernel_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int BW = 3;
  localparam int BH = 3;
`ifdef KERNEL_CTRL_BORDER_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif
  localparam int EXP_KEPT = PASS ? (H - BH + 1) * W : (W - BW + 1) * (H - BH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, frame_done;

  int total = 0;
  int bad   = 0;

  kernel_ctrl_if #(.COL_W(3), .ROW_W(3)) kif ();

  kernel_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .kbus       (kif)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All status/stream outputs packed for "everything is zero" checks.
  function automatic logic [31:0] out_vec();
    return {17'd0, kif.lb_k_ready, kif.k_valid, busy, frame_done,
            kif.k_sof, kif.k_eol, kif.k_eof, kif.k_col, kif.k_row};
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams one frame from the source side. The expected behaviour of source
  // kernel n (column n%W of its rightmost pixel, row n/W) is derived directly
  // from the keep rule. Returns after stop_after handshakes when non-zero.
  task automatic run_frame(input int vprob, input int rprob, input bit rand_start,
                           input bit do_stall, input int stop_after, output int kept);
    int  n = 0;
    int  cyc = 0;
    bit  eof_hs = 1'b0;
    bit  stall_done = 1'b0;
    bit  lbv, rdy, exp_keep, exp_sof, exp_eol, exp_eof;
    int  c, r, exp_col;
    kept = 0;
    while (1) begin
      if (cyc >= 2000) begin
        check_val("frame_timeout", 32'd0, 32'd1);
        break;
      end
      c = n % W;
      r = n / W;
      if (do_stall && !stall_done && c == 5 && r == 1) begin
        for (int s = 0; s < 5; s++) begin
          kif.lb_k_valid = 1'b1;
          kif.k_ready    = 1'b0;
          #1;
          check_val("stall_lb_ready", kif.lb_k_ready, 1'b0);
          check_val("stall_pos", {kif.k_valid, kif.k_col, kif.k_row}, {1'b1, 3'd3, 3'd1});
          @(posedge clk); #1;
        end
        stall_done = 1'b1;
      end
      lbv = ($urandom_range(99) < vprob);
      rdy = ($urandom_range(99) < rprob);
      kif.lb_k_valid = lbv;
      kif.k_ready    = rdy;
      start = rand_start ? ($urandom_range(3) == 0) : 1'b0;
      #1;
      if (eof_hs) begin
        check_val("done_cycle", {frame_done, busy, kif.lb_k_ready, kif.k_valid}, 4'b1000);
        break;
      end
      exp_keep = PASS || (c >= BW - 1);
      exp_col  = (c >= BW - 1) ? c - (BW - 1) : 0;
      exp_sof  = PASS ? (c == 0 && r == 0) : (exp_col == 0 && r == 0);
      exp_eol  = (c == W - 1);
      exp_eof  = exp_eol && (r == H - BH);
      check_val("stream_status", {busy, frame_done}, 2'b10);
      if (lbv) check_val("k_valid", kif.k_valid, exp_keep);
      if (exp_keep) check_val("lb_ready_follow", kif.lb_k_ready, rdy);
      else          check_val("border_drain", kif.lb_k_ready, 1'b1);
      if (lbv && kif.lb_k_ready) begin
        if (exp_keep) begin
          check_val("kernel_fields",
                    {kif.k_col, kif.k_row, kif.k_sof, kif.k_eol, kif.k_eof},
                    {exp_col[2:0], r[2:0], exp_sof, exp_eol, exp_eof});
`ifdef KERNEL_CTRL_BORDER_PASS_EN
          check_val("k_border", kif.k_border, (c < BW - 1));
`endif
          kept++;
        end
        n++;
        if (exp_eof) eof_hs = 1'b1;
        if (stop_after > 0 && n >= stop_after) begin
          @(posedge clk); #1;
          return;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    kif.lb_k_valid = 1'b0;
    kif.k_ready = 1'b1;
    #1;
    check_val("idle_after_done", {busy, frame_done, kif.lb_k_ready, kif.k_valid}, 4'b0000);
    check_val("kept_count", kept, EXP_KEPT);
  endtask

  initial begin
    int kept;
    kif.lb_k_valid = 1'b1;
    kif.k_ready    = 1'b1;
    #1;
    check_val("reset_outputs", out_vec(), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    kif.lb_k_valid = 1'b0;
    @(posedge clk); #1;
    check_val("idle_wait_start", {busy, kif.lb_k_ready, kif.k_valid}, 3'b000);
    start = 1'b1;
    #1;
    check_val("idle_no_ready", {kif.lb_k_ready, kif.k_valid}, 2'b00);
    @(posedge clk); #1;
    start = 1'b0;

    // Full-rate frame.
    run_frame(100, 100, 1'b0, 1'b0, 0, kept);
    // Random valid/ready.
    start_pulse();
    run_frame(70, 70, 1'b0, 1'b0, 0, kept);
    // Directed back-pressure on kernel (3,1).
    start_pulse();
    run_frame(100, 100, 1'b0, 1'b1, 0, kept);
    // Mid-frame reset after 10 handshakes.
    start_pulse();
    run_frame(100, 100, 1'b0, 1'b0, 10, kept);
    kif.lb_k_valid = 1'b1;
    kif.k_ready    = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_val("midframe_reset", out_vec(), 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("no_resume", {busy, kif.k_valid}, 2'b00);
    start_pulse();
    run_frame(100, 100, 1'b0, 1'b0, 0, kept);
    // Spurious starts while streaming.
    start_pulse();
    run_frame(80, 60, 1'b1, 1'b0, 0, kept);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
